hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a classic 5-stage core.
//
// Decides, every cycle, whether the front end advances, stalls or is flushed:
//   * redirect (branch mispredict / jump) resolved in EX flushes IF/ID and ID/EX
//   * a multiply/divide starting in EX freezes IF/ID and ID/EX for MD_LAT cycles
//   * a load in EX feeding an instruction in ID inserts LOAD_STALL bubbles
//
// Parameters:
//   REG_AW      register-specifier width
//   LOAD_STALL  load-use bubble count (1..3)
//   MD_LAT      multiply/divide EX occupancy in cycles, start cycle included (2..15)
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   next_type         EX resolution: 00 PC+4, 01 predicted ok, 10 mispredict, 11 jump
//   idex_mem_read     load in EX
//   idex_rt           destination of the load in EX
//   ifid_rs, ifid_rt  source specifiers of the instruction in ID
//   ifid_uses_rt      ifid_rt is a real source (compare it)
//   idex_md_start     mul/div begins in EX this cycle
//   pc_write          PC may update
//   pc_src            00 PC+4, 01 jump target, 10 ID/EX PC (mispredict recovery)
//   ifid_stall/flush  IF/ID register hold / clear
//   idex_stall/flush  ID/EX register hold / clear (flush inserts a bubble)
//   md_busy           mul/div unit occupies EX
//   stall_cycles      cycles with pc_write=0 since reset
//   flush_events      cycles with ifid_flush=1 since reset
//
// Configuration:
//   HAZARD_PERF_CNT_EN  when defined, stall_cycles/flush_events are live 32-bit
//                       wrapping counters; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        next_type,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              idex_md_start,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              md_busy,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LD_STALL = 2'd1,
    S_MD_STALL = 2'd2
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_IDEXPC = 2'b10;

  // Cycles still to spend in the stall state after the cycle that entered it.
  localparam logic [3:0] LD_INIT = 4'(LOAD_STALL - 1);
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic redirect;
  logic load_hit;

  // next_type[1] set means 10 (mispredict) or 11 (jump).
  assign redirect = next_type[1];

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_hit = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state variable gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    pc_src     = PC_SRC_SEQ;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    md_busy    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          pc_src     = next_type[0] ? PC_SRC_JUMP : PC_SRC_IDEXPC;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (idex_md_start) begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          md_busy    = 1'b1;
          state_d    = S_MD_STALL;
          cnt_d      = MD_INIT;
        end else if (load_hit) begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          // A single bubble is fully covered by this cycle; no state needed.
          if (LOAD_STALL > 1) begin
            state_d = S_LD_STALL;
            cnt_d   = LD_INIT;
          end
        end
      end

      S_LD_STALL: begin
        if (redirect) begin
          // The stalled instruction is on the wrong path anyway: drop it.
          pc_src     = next_type[0] ? PC_SRC_JUMP : PC_SRC_IDEXPC;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = S_RUN;
          cnt_d      = '0;
        end else begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      S_MD_STALL: begin
        // The mul/div owns EX: whatever EX reports now is stale, ignore it.
        pc_write   = 1'b0;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
        md_busy    = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    // While in reset the pipeline is held empty: no PC update, both
    // pipeline registers cleared.
    if (!rst_n) begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_SEQ;
      ifid_stall = 1'b0;
      ifid_flush = 1'b1;
      idex_stall = 1'b0;
      idex_flush = 1'b1;
      md_busy    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^32.
  assign stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write};
  assign flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- scoreboard bench for hazard_ctrl.
// Two instances share the stimulus: A (LOAD_STALL=1, MD_LAT=4) and
// B (LOAD_STALL=3, MD_LAT=6). The reference model tracks stall windows as
// absolute cycle numbers; the driver pushes expected results per cycle, the
// monitor pops and compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int AW = 5;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       md_busy;
  } ctl_t;

  typedef struct packed {
    int          cyc;
    ctl_t        ctl;
    logic [31:0] st;
    logic [31:0] fl;
    logic        chk_perf;
  } exp_t;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    next_type = '0;
  logic          idex_mem_read = 1'b0;
  logic [AW-1:0] idex_rt = '0;
  logic [AW-1:0] ifid_rs = '0;
  logic [AW-1:0] ifid_rt = '0;
  logic          ifid_uses_rt = 1'b0;
  logic          idex_md_start = 1'b0;

  logic        a_pc_write, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush, a_md_busy;
  logic [1:0]  a_pc_src;
  logic [31:0] a_stall_cycles, a_flush_events;
  logic        b_pc_write, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush, b_md_busy;
  logic [1:0]  b_pc_src;
  logic [31:0] b_stall_cycles, b_flush_events;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(1), .MD_LAT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .next_type(next_type),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_md_start(idex_md_start),
    .pc_write(a_pc_write), .pc_src(a_pc_src),
    .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
    .idex_stall(a_idex_stall), .idex_flush(a_idex_flush),
    .md_busy(a_md_busy),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(3), .MD_LAT(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .next_type(next_type),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_md_start(idex_md_start),
    .pc_write(b_pc_write), .pc_src(b_pc_src),
    .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
    .idex_stall(b_idex_stall), .idex_flush(b_idex_flush),
    .md_busy(b_md_busy),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int   checks   = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   drv_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Stall windows are kept as "blocked until cycle N" per instance.
  int          ls_p[2] = '{1, 3};
  int          ml_p[2] = '{4, 6};
  int          ld_end[2] = '{-1, -1};
  int          md_end[2] = '{-1, -1};
  logic [31:0] acc_st[2] = '{32'd0, 32'd0};
  logic [31:0] acc_fl[2] = '{32'd0, 32'd0};
  int          cyc = 0;

  function automatic ctl_t mk(input bit pw, input logic [1:0] src, input bit fs,
                              input bit ff, input bit es, input bit ef, input bit mb);
    ctl_t c;
    c.pc_write = pw; c.pc_src = src; c.ifid_stall = fs; c.ifid_flush = ff;
    c.idex_stall = es; c.idex_flush = ef; c.md_busy = mb;
    return c;
  endfunction

  task automatic model(input int k, output exp_t e);
    ctl_t c;
    bit   hit;
    hit = idex_mem_read && (idex_rt != 0) &&
          ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    if (!rst_n) begin
      c = mk(0, 2'b00, 0, 1, 0, 1, 0);
      ld_end[k] = -1;
      md_end[k] = -1;
    end else if (cyc < md_end[k]) begin
      c = mk(0, 2'b00, 1, 0, 1, 0, 1);
    end else if (next_type == 2'b10 || next_type == 2'b11) begin
      c = mk(1, (next_type == 2'b11) ? 2'b01 : 2'b10, 0, 1, 0, 1, 0);
      ld_end[k] = -1;
    end else if (cyc < ld_end[k]) begin
      c = mk(0, 2'b00, 1, 0, 0, 1, 0);
    end else if (idex_md_start) begin
      c = mk(0, 2'b00, 1, 0, 1, 0, 1);
      md_end[k] = cyc + ml_p[k];
    end else if (hit) begin
      c = mk(0, 2'b00, 1, 0, 0, 1, 0);
      ld_end[k] = cyc + ls_p[k];
    end else begin
      c = mk(1, 2'b00, 0, 0, 0, 0, 0);
    end
    e.cyc      = cyc;
    e.ctl      = c;
    e.st       = acc_st[k];
    e.fl       = acc_fl[k];
    e.chk_perf = rst_n;
    if (!rst_n) begin
      acc_st[k] = 32'd0;
      acc_fl[k] = 32'd0;
    end else if (PERF_EN) begin
      acc_st[k] = acc_st[k] + (c.pc_write ? 32'd0 : 32'd1);
      acc_fl[k] = acc_fl[k] + (c.ifid_flush ? 32'd1 : 32'd0);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue expectations.
  task automatic drive(input bit rn, input logic [1:0] nt, input bit mr, input int drt,
                       input int rs, input int rt, input bit uses, input bit md);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst_n         = rn;
    next_type     = nt;
    idex_mem_read = mr;
    idex_rt       = AW'(drt);
    ifid_rs       = AW'(rs);
    ifid_rt       = AW'(rt);
    ifid_uses_rt  = uses;
    idex_md_start = md;
    model(0, ea);
    model(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    idle(1);
    // single load-use hit through rs
    drive(1, 2'b00, 1, 5, 5, 0, 0, 0);
    idle(4);
    // idex_rt=0 never stalls; rt match ignored unless used
    drive(1, 2'b00, 1, 0, 0, 0, 1, 0);
    drive(1, 2'b01, 1, 7, 1, 7, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1, 2'b00, 1, 7, 1, 7, 1, 0);
    idle(2);
    // mul/div start, mispredicts during occupancy ignored
    drive(1, 2'b00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 2'b10, 1, 3, 3, 0, 0, 1);
    idle(3);
    // redirect beats a simultaneous load hit
    drive(1, 2'b10, 1, 4, 4, 0, 0, 0);
    drive(1, 2'b11, 1, 4, 4, 0, 0, 0);
    idle(1);
    // redirect arriving in the middle of a multi-cycle load stall
    drive(1, 2'b00, 1, 6, 6, 0, 0, 0);
    drive(1, 2'b11, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset in the second cycle of a mul/div stall
    drive(1, 2'b00, 0, 0, 0, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    idle(3);
    // counter scenario: fresh reset, 3-cycle load stall, one jump
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2'b00, 1, 9, 9, 0, 0, 0);
    drive(1, 2'b11, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [1:0]  nt;
      r  = $urandom_range(0, 9);
      nt = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'($urandom_range(0, 1));
      drive(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, nt,
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end
    idle(2);
    drv_done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    int   budget;
    ctl_t act;
    exp_t e;
    budget = 0;
    forever begin
      @(negedge clk);
      budget++;
      if (q_a.size() > 0) begin
        e   = q_a.pop_front();
        act = mk(a_pc_write, a_pc_src, a_ifid_stall, a_ifid_flush,
                 a_idex_stall, a_idex_flush, a_md_busy);
        check($sformatf("A.ctl cyc=%0d", e.cyc), 64'(act), 64'(e.ctl));
        if (e.chk_perf)
          check($sformatf("A.perf cyc=%0d", e.cyc), {a_stall_cycles, a_flush_events}, {e.st, e.fl});
      end
      if (q_b.size() > 0) begin
        e   = q_b.pop_front();
        act = mk(b_pc_write, b_pc_src, b_ifid_stall, b_ifid_flush,
                 b_idex_stall, b_idex_flush, b_md_busy);
        check($sformatf("B.ctl cyc=%0d", e.cyc), 64'(act), 64'(e.ctl));
        if (e.chk_perf)
          check($sformatf("B.perf cyc=%0d", e.cyc), {b_stall_cycles, b_flush_events}, {e.st, e.fl});
      end
      if (drv_done && q_a.size() == 0 && q_b.size() == 0) break;
      if (budget > 20000) begin
        check("timeout", 64'(budget), 64'd0);
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
